// File: rtl/uart_pkg.sv
// Shared types and constants for the UART framing path.
package uart_pkg;

  localparam logic [7:0] SYNC_DEFAULT = 8'hA5;

  typedef enum logic [2:0] {
    HUNT    = 3'd0,
    ADDR    = 3'd1,
    LEN     = 3'd2,
    PAYLOAD = 3'd3,
    CHK     = 3'd4,
    FLUSH   = 3'd5
  } state_e;

  // Reject causes, available for debug taps.
  typedef enum logic [1:0] {
    NO_ERR  = 2'd0,
    LEN_ERR = 2'd1,
    CHK_ERR = 2'd2,
    TMO_ERR = 2'd3
  } err_e;

endpackage

// File: rtl/uart_counter.sv
// Free-running modulo-N counter with a synchronous clear and a terminal-count strobe.
module uart_counter #(
  parameter int N = 16
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_rst,
  input  logic i_ce,
  output logic o_ov
);

  localparam int W = (N > 2) ? $clog2(N) : 1;

  logic [W-1:0] cnt_q;

  // Strobe on the last count of the period.
  assign o_ov = i_ce && (cnt_q == W'(N - 1));

  // Count while enabled, wrap at N, clear on request.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n)      cnt_q <= '0;
    else if (i_rst)    cnt_q <= '0;
    else if (i_ce)     cnt_q <= (cnt_q == W'(N - 1)) ? '0 : cnt_q + W'(1);
  end

endmodule

// File: rtl/uart_frame_ctrl.sv
// Frame parser: SYNC, ADDR, LEN, payload, XOR checksum; commits buffered writes on good checksum.
module uart_frame_ctrl
  import uart_pkg::*;
#(
  parameter int         F       = 50000000,
  parameter int         MAX_LEN = 16,
  parameter int         TIMEOUT = 100000,
  parameter logic [7:0] SYNC    = SYNC_DEFAULT
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic [7:0] i_data,
  input  logic       i_valid,
  output logic       o_ready,
  output logic       o_wr_en,
  output logic [7:0] o_wr_addr,
  output logic [7:0] o_wr_data,
  input  logic       i_wr_ready,
  output logic       o_frame_ok,
  output logic       o_frame_err,
  output logic       o_busy
);

  localparam int         IW        = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
  localparam logic [7:0] MAX_LEN_B = 8'(MAX_LEN);

  if (F <= 0)                       begin : g_bad_f   $error("F must be positive");          end
  if (MAX_LEN < 1 || MAX_LEN > 255) begin : g_bad_len $error("MAX_LEN must be 1..255");      end
  if (TIMEOUT < 2)                  begin : g_bad_tmo $error("TIMEOUT must be at least 2");  end

  state_e     state_q, state_d;
  logic [7:0] base_q, len_q, idx_q, xor_q;
  logic [7:0] pbuf_q [MAX_LEN];
  logic       wr_en_q, ok_q, err_q, busy_q;
  logic [7:0] wr_addr_q, wr_data_q;

  logic       accept, counting, tmo, last_wr;
  logic [7:0] idx_nxt;

  assign o_ready     = (state_q != FLUSH);
  assign accept      = i_valid && o_ready;
  assign counting    = (state_q == ADDR) || (state_q == LEN) ||
                       (state_q == PAYLOAD) || (state_q == CHK);
  assign idx_nxt     = idx_q + 8'd1;
  assign last_wr     = (idx_q == len_q - 8'd1);

  assign o_wr_en     = wr_en_q;
  assign o_wr_addr   = wr_addr_q;
  assign o_wr_data   = wr_data_q;
  assign o_frame_ok  = ok_q;
  assign o_frame_err = err_q;
  assign o_busy      = busy_q;

  // Inter-byte watchdog: restarts on each accepted byte, idle outside the parse states.
  uart_counter #(.N(TIMEOUT)) u_tmo (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_rst   (accept || !counting),
    .i_ce    (1'b1),
    .o_ov    (tmo)
  );

  // Next-state decode; an accepted byte takes priority over a coincident timeout.
  always_comb begin
    state_d = state_q;
    if (state_q == FLUSH) begin
      if (wr_en_q && i_wr_ready && last_wr) state_d = HUNT;
    end else if (accept) begin
      unique case (state_q)
        HUNT:    if (i_data == SYNC) state_d = ADDR;
        ADDR:    state_d = LEN;
        LEN: begin
          if (i_data > MAX_LEN_B)  state_d = HUNT;
          else if (i_data == 8'd0) state_d = CHK;
          else                     state_d = PAYLOAD;
        end
        PAYLOAD: if (last_wr) state_d = CHK;
        CHK:     state_d = ((i_data == xor_q) && (len_q != 8'd0)) ? FLUSH : HUNT;
        default: state_d = HUNT;
      endcase
    end else if (tmo) begin
      state_d = HUNT;
    end
  end

  // Control, checksum and write-port registers.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q   <= HUNT;
      base_q    <= '0;
      len_q     <= '0;
      idx_q     <= '0;
      xor_q     <= '0;
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
      ok_q      <= 1'b0;
      err_q     <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      busy_q  <= (state_d != HUNT);
      ok_q    <= 1'b0;
      err_q   <= 1'b0;
      if (accept) begin
        unique case (state_q)
          ADDR: begin
            base_q <= i_data;
            xor_q  <= i_data;
          end
          LEN: begin
            len_q <= i_data;
            xor_q <= xor_q ^ i_data;
            idx_q <= '0;
            if (i_data > MAX_LEN_B) err_q <= 1'b1;
          end
          PAYLOAD: begin
            xor_q <= xor_q ^ i_data;
            idx_q <= idx_nxt;
          end
          CHK: begin
            if (i_data != xor_q) begin
              err_q <= 1'b1;
            end else if (len_q == 8'd0) begin
              ok_q <= 1'b1;
            end else begin
              wr_en_q   <= 1'b1;
              wr_addr_q <= base_q;
              wr_data_q <= pbuf_q[0];
              idx_q     <= '0;
            end
          end
          default: ;
        endcase
      end else if (counting && tmo) begin
        err_q <= 1'b1;
      end
      if (state_q == FLUSH && wr_en_q && i_wr_ready) begin
        if (last_wr) begin
          wr_en_q <= 1'b0;
          ok_q    <= 1'b1;
        end else begin
          idx_q     <= idx_nxt;
          wr_addr_q <= base_q + idx_nxt;
          wr_data_q <= pbuf_q[idx_nxt[IW-1:0]];
        end
      end
    end
  end

  // Payload storage; contents are only meaningful after a full payload is captured.
  always_ff @(posedge i_clk) begin
    if (accept && state_q == PAYLOAD) pbuf_q[idx_q[IW-1:0]] <= i_data;
  end

endmodule
